// File: rtl/uart_pkg.sv
// Shared UART types: receiver state encoding, parity modes and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Callers zero-extend narrower data; extra zeros leave the XOR unchanged.
  function automatic logic parity_bit(input logic [31:0] data, input int mode);
    case (mode)
      PARITY_ODD:  return ~^data;
      PARITY_EVEN: return ^data;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous level, with a selectable reset value.
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: reset to the line's idle level so leaving reset never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: deframes start/data/parity/stop bits and writes good bytes into the RX FIFO.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DSIZE        = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             rx,
  input  logic             wfull,
  output logic             winc,
  output logic [DSIZE-1:0] wdata,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DSIZE + 1);
  localparam logic [CW-1:0] MID_CNT  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_CNT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DSIZE - 1);

  logic             rx_sync;
  logic             rx_prev;
  logic             rx_fall;
  logic             bit_tick;
  rx_state_t        state;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    bit_idx;
  logic [DSIZE-1:0] shift;
  logic             par_mismatch;

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk   (wclk),
    .rst_n (wrst_n),
    .d     (rx),
    .q     (rx_sync)
  );

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) rx_prev <= 1'b1;
    else         rx_prev <= rx_sync;
  end

  assign rx_fall  = rx_prev & ~rx_sync;
  // After the mid-start sample the counter is cleared, so a full period later is mid-bit again.
  assign bit_tick = (cnt == BIT_CNT);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      par_mismatch <= 1'b0;
      busy         <= 1'b0;
      winc         <= 1'b0;
      wdata        <= '0;
      frame_err    <= 1'b0;
      parity_err   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults make every strobe exactly one cycle wide.
      winc       <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      cnt        <= cnt + CW'(1);

      case (state)
        IDLE: begin
          cnt <= '0;
          if (rx_fall) begin
            state <= START;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (cnt == MID_CNT) begin
            cnt <= '0;
            if (!rx_sync) begin
              state        <= DATA;
              bit_idx      <= '0;
              par_mismatch <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        DATA: begin
          if (bit_tick) begin
            cnt     <= '0;
            shift   <= {rx_sync, shift[DSIZE-1:1]};
            bit_idx <= bit_idx + BW'(1);
            if (bit_idx == LAST_BIT) begin
              if (PARITY != PARITY_NONE) state <= uart_pkg::PARITY;
              else                       state <= STOP;
            end
          end
        end

        // The module parameter shadows the enum literal, hence the package-qualified name.
        uart_pkg::PARITY: begin
          if (bit_tick) begin
            cnt          <= '0;
            par_mismatch <= (rx_sync != parity_bit(32'(shift), PARITY));
            state        <= STOP;
          end
        end

        STOP: begin
          if (bit_tick) begin
            cnt <= '0;
            if (!rx_sync) begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              if (par_mismatch) begin
                parity_err <= 1'b1;
              end else if (wfull) begin
                overrun <= 1'b1;
              end else begin
                wdata <= shift;
                winc  <= 1'b1;
              end
            end
          end
        end

        BREAK: begin
          if (rx_sync) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
